multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore-style multicycle control FSM for the 16-bit datapath. Consumes the datapath's decoded fields (OP_CODE, OP_EXT, Rdest_addr) and the latched flags (PSR_OUT).
- Drives every mux select, register enable and regfile write, plus the memory write strobe.
- Sits directly upstream of the datapath; one instance per CPU, sharing its clock and reset.

Parameters:
- PSRL, 5, PSR width; bit order is {N,Z,F,L,C} = PSR_OUT[4:0].
- OPL, 4, width of OP_CODE, OP_EXT and the condition field.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- OP_CODE  in  4  INSTR[15:12].
- OP_EXT  in  4  INSTR[7:4].
- Rdest_addr  in  4  INSTR[11:8]; used as the condition code for Jcond/Bcond.
- PSR_OUT  in  5  latched flags {N,Z,F,L,C}.
- PC_S  out  1  0=Rsrc, 1=ALU result into PC.
- MEM_S  out  1  0=Rsrc, 1=PC as memory address.
- WD_S  out  2  regfile write data: 00 IMM_EXT, 01 Rsrc, 10 mem data reg, 11 ALU out reg.
- ALUA_S  out  2  ALU A input: 00 Rsrc, 01 PC, 10 IMM_EXT.
- ALUB_S  out  2  ALU B input: 00 Rdest, 01 IMM_EXT, 10 constant 1.
- INSTR_EN, ALU_OUT_EN, MEM_REG_EN, PC_EN, PSR_EN  out  1 each  register load enables.
- SE_SIGN  out  1  1 = sign-extend the immediate.
- REG_WR  out  1  regfile write enable.
- MEM_WE  out  1  data memory write strobe (writes Rdest to mem[Rsrc]).
- STATE  out  4  current state encoding, for debug.

Behaviour:
- Memory is a synchronous read with 1-cycle latency. Outputs are a pure decode of the state register plus the latched instruction fields. Any output not listed for a state is 0.
- Reset asserted, any cycle:
  - State goes to FETCH immediately.
  - All enables, REG_WR and MEM_WE are 0 while reset is low.
  - An in-flight instruction is abandoned with no write.
  - First rising edge after release executes FETCH.
- FETCH: MEM_S=1. Next state is FWAIT.
- FWAIT:
  - MEM_S=1, INSTR_EN=1.
  - ALUA_S=01, ALUB_S=10, PC_S=1, PC_EN=1, giving PC<=PC+1. The datapath forces ADD while PC_EN=1.
  - Next state is DECODE.
- DECODE: Rsrc/Rdest are captured by the datapath this cycle. Next state depends on the opcode:
  - OP 0000, EXT in {0101 ADD, 1001 SUB, 1011 CMP, 0001 AND, 0010 OR, 0011 XOR}: go to REXEC.
  - OP 0000, EXT 1101 (MOV): go to MOVWB.
  - OP in {0101, 1001, 1011, 0001, 0010, 0011} (immediate forms): go to IEXEC.
  - OP 1101 (MOVI): written in DECODE itself with WD_S=00, SE_SIGN=0, REG_WR=1. Next state is FETCH.
  - OP 0100, EXT 0000 (LOAD): go to LDADDR.
  - OP 0100, EXT 0100 (STOR): go to STWR.
  - OP 0100, EXT 1100 (Jcond): go to JUMP.
  - OP 1100 (Bcond): go to BRANCH.
  - Any other encoding: go to FETCH with no write. This is a 3-cycle NOP.
- REXEC: ALUA_S=00, ALUB_S=00, ALU_OUT_EN=1. PSR_EN=1 for ADD/SUB/CMP only. Next state is FETCH for CMP, otherwise ALUWB.
- IEXEC: ALUA_S=10, ALUB_S=00, ALU_OUT_EN=1. SE_SIGN=1 for ADDI/SUBI/CMPI, 0 for logic ops. PSR_EN=1 for ADDI/SUBI/CMPI. Next state is FETCH for CMPI, otherwise ALUWB.
- ALUWB: WD_S=11, REG_WR=1. Next state is FETCH.
- MOVWB: WD_S=01, REG_WR=1. Next state is FETCH.
- Load sequence:
  - LDADDR: MEM_S=0. Next state is LDLAT.
  - LDLAT: MEM_S=0, MEM_REG_EN=1. Next state is LDWB.
  - LDWB: WD_S=10, REG_WR=1. Next state is FETCH.
- STWR: MEM_S=0, MEM_WE=1 for exactly one cycle. Next state is FETCH.
- JUMP: if cond is true, PC_S=0, PC_EN=1 (PC<=Rsrc). Next state is FETCH.
- BRANCH: if cond is true, ALUA_S=01, ALUB_S=01, SE_SIGN=1, PC_S=1, PC_EN=1 (PC<=PC+1+disp). Next state is FETCH.
- Condition codes (all evaluated on PSR_OUT in the same cycle):
  - 0000 EQ: Z.
  - 0001 NE: !Z.
  - 0010 CS: C.
  - 0011 CC: !C.
  - 0100 HI: L.
  - 0101 LS: !L.
  - 0110 GT: N.
  - 0111 LE: !N.
  - 1000 FS: F.
  - 1001 FC: !F.
  - 1010 LO: !L&!Z.
  - 1011 HS: L|Z.
  - 1100 LT: !N&!Z.
  - 1101 GE: N|Z.
  - 1110 UC: 1.
  - 1111: never taken.
- Cycle counts:
  - MOVI and illegal encodings: 3.
  - CMP/CMPI, MOV, STOR, Jcond, Bcond: 4.
  - ALU ops with writeback: 5.
  - LOAD: 6.
- Exclusivity invariants:
  - Never assert REG_WR and MEM_WE in the same cycle.
  - PC_EN is asserted at most twice per instruction.
  - STATE encoding is one-hot-free binary. Unreachable codes recover to FETCH on the next edge.

Test Plan:
- Reset low mid-LDLAT, release 2 cycles later -> REG_WR=0 throughout; STATE=FETCH; first post-reset FWAIT asserts INSTR_EN=1, PC_EN=1.
- OP=0000 EXT=0101 (ADD) -> 5-cycle sequence; REXEC shows ALU_OUT_EN=1, PSR_EN=1; ALUWB shows WD_S=11, REG_WR=1.
- OP=1011 (CMPI), then OP=0001 (ANDI) -> CMPI takes 4 cycles, SE_SIGN=1, PSR_EN=1, no REG_WR; ANDI takes SE_SIGN=0, PSR_EN=0, REG_WR=1 in ALUWB.
- OP=0100 EXT=0000, then EXT=0100 -> LOAD: MEM_S=0 two cycles, then MEM_REG_EN, then WD_S=10 write. STOR: MEM_WE high exactly 1 cycle, REG_WR never high.
- Bcond cond=0000 with PSR_OUT=5'b01000, then PSR_OUT=5'b00000 -> first: PC_EN=1, PC_S=1, ALUB_S=01 in BRANCH. Second: PC_EN=0.
- Jcond cond=1111, then cond=1110; OP=0111 illegal -> never: PC_EN=0; UC: PC_S=0, PC_EN=1; illegal: back to FETCH after DECODE with all writes 0.

Source files
------------

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Multicycle control FSM for the 16-bit datapath. Steps each
//            instruction through fetch, decode and execute states and drives
//            the datapath mux selects, register enables and write strobes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller #(
  parameter int PSRL = 5,
  parameter int OPL  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OPL-1:0]  OP_CODE,
  input  logic [OPL-1:0]  OP_EXT,
  input  logic [OPL-1:0]  Rdest_addr,
  input  logic [PSRL-1:0] PSR_OUT,
  output logic            PC_S,
  output logic            MEM_S,
  output logic [1:0]      WD_S,
  output logic [1:0]      ALUA_S,
  output logic [1:0]      ALUB_S,
  output logic            INSTR_EN,
  output logic            ALU_OUT_EN,
  output logic            MEM_REG_EN,
  output logic            PC_EN,
  output logic            PSR_EN,
  output logic            SE_SIGN,
  output logic            REG_WR,
  output logic            MEM_WE,
  output logic [3:0]      STATE
);

  // ALU operation codes; the immediate forms reuse the same values as OP_CODE
  localparam logic [OPL-1:0] C_ADD     = 4'b0101;
  localparam logic [OPL-1:0] C_SUB     = 4'b1001;
  localparam logic [OPL-1:0] C_CMP     = 4'b1011;
  localparam logic [OPL-1:0] C_AND     = 4'b0001;
  localparam logic [OPL-1:0] C_OR      = 4'b0010;
  localparam logic [OPL-1:0] C_XOR     = 4'b0011;
  localparam logic [OPL-1:0] C_MOV     = 4'b1101;
  localparam logic [OPL-1:0] OP_RTYPE  = 4'b0000;
  localparam logic [OPL-1:0] OP_MEM    = 4'b0100;
  localparam logic [OPL-1:0] OP_BCOND  = 4'b1100;
  localparam logic [OPL-1:0] EXT_LOAD  = 4'b0000;
  localparam logic [OPL-1:0] EXT_STOR  = 4'b0100;
  localparam logic [OPL-1:0] EXT_JCOND = 4'b1100;

  // FETCH is code 0 so the reset value of STATE reads as zero on the debug port
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    FWAIT  = 4'd1,
    DECODE = 4'd2,
    REXEC  = 4'd3,
    IEXEC  = 4'd4,
    ALUWB  = 4'd5,
    MOVWB  = 4'd6,
    LDADDR = 4'd7,
    LDLAT  = 4'd8,
    LDWB   = 4'd9,
    STWR   = 4'd10,
    JUMP   = 4'd11,
    BRANCH = 4'd12
  } state_t;

  state_t state;
  state_t decode_next;
  logic   cond_true;

  function automatic logic is_alu(input logic [OPL-1:0] code);
    return (code == C_ADD) || (code == C_SUB) || (code == C_CMP) ||
           (code == C_AND) || (code == C_OR)  || (code == C_XOR);
  endfunction

  // Arithmetic ops update the flags and take a sign-extended immediate
  function automatic logic is_arith(input logic [OPL-1:0] code);
    return (code == C_ADD) || (code == C_SUB) || (code == C_CMP);
  endfunction

  // Condition evaluation on the latched flags {N,Z,F,L,C}
  always_comb begin
    cond_true = 1'b0;
    case (Rdest_addr)
      4'b0000: cond_true =  PSR_OUT[3];
      4'b0001: cond_true = !PSR_OUT[3];
      4'b0010: cond_true =  PSR_OUT[0];
      4'b0011: cond_true = !PSR_OUT[0];
      4'b0100: cond_true =  PSR_OUT[1];
      4'b0101: cond_true = !PSR_OUT[1];
      4'b0110: cond_true =  PSR_OUT[4];
      4'b0111: cond_true = !PSR_OUT[4];
      4'b1000: cond_true =  PSR_OUT[2];
      4'b1001: cond_true = !PSR_OUT[2];
      4'b1010: cond_true = !PSR_OUT[1] && !PSR_OUT[3];
      4'b1011: cond_true =  PSR_OUT[1] ||  PSR_OUT[3];
      4'b1100: cond_true = !PSR_OUT[4] && !PSR_OUT[3];
      4'b1101: cond_true =  PSR_OUT[4] ||  PSR_OUT[3];
      4'b1110: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // Opcode dispatch out of DECODE; unknown encodings fall back to FETCH as a NOP
  always_comb begin
    decode_next = FETCH;
    if (OP_CODE == OP_RTYPE) begin
      if (is_alu(OP_EXT))        decode_next = REXEC;
      else if (OP_EXT == C_MOV)  decode_next = MOVWB;
    end else if (is_alu(OP_CODE)) begin
      decode_next = IEXEC;
    end else if (OP_CODE == OP_MEM) begin
      if (OP_EXT == EXT_LOAD)       decode_next = LDADDR;
      else if (OP_EXT == EXT_STOR)  decode_next = STWR;
      else if (OP_EXT == EXT_JCOND) decode_next = JUMP;
    end else if (OP_CODE == OP_BCOND) begin
      decode_next = BRANCH;
    end
  end

  // State register; reset abandons any in-flight instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:   state <= FWAIT;
        FWAIT:   state <= DECODE;
        DECODE:  state <= decode_next;
        REXEC:   state <= (OP_EXT  == C_CMP) ? FETCH : ALUWB;
        IEXEC:   state <= (OP_CODE == C_CMP) ? FETCH : ALUWB;
        LDADDR:  state <= LDLAT;
        LDLAT:   state <= LDWB;
        default: state <= FETCH;
      endcase
    end
  end

  assign STATE = state;

  // Output decode. Kept combinational because MOVI writes in DECODE, the same
  // cycle its fields first appear from the instruction register.
  always_comb begin
    PC_S       = 1'b0;
    MEM_S      = 1'b0;
    WD_S       = 2'b00;
    ALUA_S     = 2'b00;
    ALUB_S     = 2'b00;
    INSTR_EN   = 1'b0;
    ALU_OUT_EN = 1'b0;
    MEM_REG_EN = 1'b0;
    PC_EN      = 1'b0;
    PSR_EN     = 1'b0;
    SE_SIGN    = 1'b0;
    REG_WR     = 1'b0;
    MEM_WE     = 1'b0;
    case (state)
      FETCH:  MEM_S = 1'b1;
      FWAIT: begin
        MEM_S    = 1'b1;
        INSTR_EN = 1'b1;
        ALUA_S   = 2'b01;
        ALUB_S   = 2'b10;
        PC_S     = 1'b1;
        PC_EN    = 1'b1;
      end
      DECODE: REG_WR = (OP_CODE == C_MOV);
      REXEC: begin
        ALU_OUT_EN = 1'b1;
        PSR_EN     = is_arith(OP_EXT);
      end
      IEXEC: begin
        ALUA_S     = 2'b10;
        ALU_OUT_EN = 1'b1;
        SE_SIGN    = is_arith(OP_CODE);
        PSR_EN     = is_arith(OP_CODE);
      end
      ALUWB: begin
        WD_S   = 2'b11;
        REG_WR = 1'b1;
      end
      MOVWB: begin
        WD_S   = 2'b01;
        REG_WR = 1'b1;
      end
      LDLAT:  MEM_REG_EN = 1'b1;
      LDWB: begin
        WD_S   = 2'b10;
        REG_WR = 1'b1;
      end
      STWR:   MEM_WE = 1'b1;
      JUMP:   PC_EN  = cond_true;
      BRANCH: begin
        if (cond_true) begin
          ALUA_S  = 2'b01;
          ALUB_S  = 2'b01;
          SE_SIGN = 1'b1;
          PC_S    = 1'b1;
          PC_EN   = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module   : tb_multicycle_controller
// Purpose  : Self-checking bench for multicycle_controller. A reference model
//            expands each instruction into its expected per-cycle control
//            vector list; directed cases are followed by random instructions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

  logic       clk;
  logic       rst_n;
  logic [3:0] op_code;
  logic [3:0] op_ext;
  logic [3:0] cc;
  logic [4:0] psr;
  logic       pc_s, mem_s, instr_en, alu_out_en, mem_reg_en, pc_en, psr_en;
  logic       se_sign, reg_wr, mem_we;
  logic [1:0] wd_s, alua_s, alub_s;
  logic [3:0] state;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_q[$];
  logic [15:0] obs;
  logic [3:0]  picks[10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h9, 4'hB, 4'hC, 4'hD};

  multicycle_controller #(.PSRL(5), .OPL(4)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .OP_CODE    (op_code),
    .OP_EXT     (op_ext),
    .Rdest_addr (cc),
    .PSR_OUT    (psr),
    .PC_S       (pc_s),
    .MEM_S      (mem_s),
    .WD_S       (wd_s),
    .ALUA_S     (alua_s),
    .ALUB_S     (alub_s),
    .INSTR_EN   (instr_en),
    .ALU_OUT_EN (alu_out_en),
    .MEM_REG_EN (mem_reg_en),
    .PC_EN      (pc_en),
    .PSR_EN     (psr_en),
    .SE_SIGN    (se_sign),
    .REG_WR     (reg_wr),
    .MEM_WE     (mem_we),
    .STATE      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {pc_s, mem_s, wd_s, alua_s, alub_s, instr_en, alu_out_en,
                mem_reg_en, pc_en, psr_en, se_sign, reg_wr, mem_we};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Packs one cycle's expected controls in the same order as obs
  function automatic logic [15:0] ctl(
      input logic pcs, input logic mems, input logic [1:0] wd, input logic [1:0] a,
      input logic [1:0] b, input logic ien, input logic aoen, input logic mren,
      input logic pcen, input logic psren, input logic se, input logic rw, input logic mwe);
    return {pcs, mems, wd, a, b, ien, aoen, mren, pcen, psren, se, rw, mwe};
  endfunction

  // Condition truth table indexed by the condition code; flags are {N,Z,F,L,C}
  function automatic logic taken(input logic [3:0] code, input logic [4:0] f);
    logic n, z, fl, l, c;
    logic [15:0] tbl;
    {n, z, fl, l, c} = f;
    tbl = {1'b0, 1'b1, n | z, !n & !z, l | z, !l & !z, !fl, fl,
           !n, n, !l, l, !c, c, !z, z};
    return tbl[code];
  endfunction

  function automatic logic alu_code(input logic [3:0] x);
    return x inside {4'h5, 4'h9, 4'hB, 4'h1, 4'h2, 4'h3};
  endfunction

  function automatic logic arith_code(input logic [3:0] x);
    return x inside {4'h5, 4'h9, 4'hB};
  endfunction

  // Reference model: full expected cycle list of one instruction
  task automatic build(input logic [3:0] op, input logic [3:0] ext,
                       input logic [3:0] code, input logic [4:0] f);
    logic t;
    exp_q.delete();
    exp_q.push_back(ctl(0,1,2'b00,2'b00,2'b00,0,0,0,0,0,0,0,0));
    exp_q.push_back(ctl(1,1,2'b00,2'b01,2'b10,1,0,0,1,0,0,0,0));
    exp_q.push_back(ctl(0,0,2'b00,2'b00,2'b00,0,0,0,0,0,0,(op == 4'hD),0));
    t = taken(code, f);
    if (op == 4'h0 && alu_code(ext)) begin
      exp_q.push_back(ctl(0,0,2'b00,2'b00,2'b00,0,1,0,0,arith_code(ext),0,0,0));
      if (ext != 4'hB) exp_q.push_back(ctl(0,0,2'b11,2'b00,2'b00,0,0,0,0,0,0,1,0));
    end else if (op == 4'h0 && ext == 4'hD) begin
      exp_q.push_back(ctl(0,0,2'b01,2'b00,2'b00,0,0,0,0,0,0,1,0));
    end else if (alu_code(op)) begin
      exp_q.push_back(ctl(0,0,2'b00,2'b10,2'b00,0,1,0,0,arith_code(op),arith_code(op),0,0));
      if (op != 4'hB) exp_q.push_back(ctl(0,0,2'b11,2'b00,2'b00,0,0,0,0,0,0,1,0));
    end else if (op == 4'h4 && ext == 4'h0) begin
      exp_q.push_back(ctl(0,0,2'b00,2'b00,2'b00,0,0,0,0,0,0,0,0));
      exp_q.push_back(ctl(0,0,2'b00,2'b00,2'b00,0,0,1,0,0,0,0,0));
      exp_q.push_back(ctl(0,0,2'b10,2'b00,2'b00,0,0,0,0,0,0,1,0));
    end else if (op == 4'h4 && ext == 4'h4) begin
      exp_q.push_back(ctl(0,0,2'b00,2'b00,2'b00,0,0,0,0,0,0,0,1));
    end else if (op == 4'h4 && ext == 4'hC) begin
      exp_q.push_back(ctl(0,0,2'b00,2'b00,2'b00,0,0,0,t,0,0,0,0));
    end else if (op == 4'hC) begin
      if (t) exp_q.push_back(ctl(1,0,2'b00,2'b01,2'b01,0,0,0,1,0,1,0,0));
      else   exp_q.push_back(ctl(0,0,2'b00,2'b00,2'b00,0,0,0,0,0,0,0,0));
    end
  endtask

  // Runs one instruction starting at a FETCH negedge; abort_at >= 0 pulls
  // reset low right after that cycle index and holds it for two cycles.
  task automatic run_instr(input logic [3:0] op, input logic [3:0] ext,
                           input logic [3:0] code, input logic [4:0] f,
                           input int abort_at);
    int pc_cnt;
    op_code = op;
    op_ext  = ext;
    cc      = code;
    psr     = f;
    build(op, ext, code, f);
    pc_cnt = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == 0) check($sformatf("fetch_state op%h", op), {12'h0, state}, 16'h0);
      check($sformatf("op%h ext%h cc%h cyc%0d", op, ext, code, i), obs, exp_q[i]);
      pc_cnt += int'(pc_en);
      if (i == abort_at) begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_state", {12'h0, state}, 16'h0);
        check("rst_async_ctl", obs, ctl(0,1,2'b00,2'b00,2'b00,0,0,0,0,0,0,0,0));
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          check($sformatf("rst_hold_ctl%0d", k), obs, ctl(0,1,2'b00,2'b00,2'b00,0,0,0,0,0,0,0,0));
        end
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
    end
    check($sformatf("pc_en_count op%h", op), 16'(pc_cnt <= 2), 16'h1);
  endtask

  initial begin
    rst_n   = 1'b0;
    op_code = '0;
    op_ext  = '0;
    cc      = '0;
    psr     = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {12'h0, state}, 16'h0);
    check("reset_ctl", obs, ctl(0,1,2'b00,2'b00,2'b00,0,0,0,0,0,0,0,0));
    rst_n = 1'b1;

    // Reset during the load latch cycle, then normal traffic
    run_instr(4'h4, 4'h0, 4'h0, 5'h00, 4);
    run_instr(4'h0, 4'h5, 4'h0, 5'h00, -1);   // ADD
    run_instr(4'hB, 4'h7, 4'h3, 5'h00, -1);   // CMPI
    run_instr(4'h1, 4'h2, 4'h1, 5'h00, -1);   // ANDI
    run_instr(4'h4, 4'h0, 4'h2, 5'h00, -1);   // LOAD
    run_instr(4'h4, 4'h4, 4'h2, 5'h00, -1);   // STOR
    run_instr(4'hC, 4'h3, 4'h0, 5'b01000, -1); // Bcond EQ taken
    run_instr(4'hC, 4'h3, 4'h0, 5'b00000, -1); // Bcond EQ not taken
    run_instr(4'h4, 4'hC, 4'hF, 5'b11111, -1); // Jcond never
    run_instr(4'h4, 4'hC, 4'hE, 5'b00000, -1); // Jcond UC
    run_instr(4'h7, 4'h0, 4'h0, 5'h00, -1);   // illegal
    run_instr(4'hD, 4'h0, 4'h0, 5'h00, -1);   // MOVI
    run_instr(4'h0, 4'hD, 4'h0, 5'h00, -1);   // MOV
    run_instr(4'h0, 4'hB, 4'h0, 5'h00, -1);   // CMP

    for (int n = 0; n < 300; n++) begin
      logic [3:0] op, ext;
      op  = ($urandom_range(0, 3) != 0) ? picks[$urandom_range(0, 9)] : 4'($urandom);
      ext = ($urandom_range(0, 3) != 0) ? picks[$urandom_range(0, 9)] : 4'($urandom);
      run_instr(op, ext, 4'($urandom), 5'($urandom), -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
